seq_addsub: RTL and testbench
=============================

Name: seq_addsub

Overview:
Parametrised multi-cycle adder/subtractor: WIDTH-bit operands processed CHUNK bits per clock through a ripple slice, carry held in a register between cycles. Replaces the fixed 4-bit combinational ripple add/sub in datapaths where area matters more than latency. Valid/ready handshake on both sides. Reports carry, signed overflow, zero and negative flags.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK, >= CHUNK.
CHUNK, 4, bits processed per cycle (slice width); NCH = WIDTH/CHUNK cycles per operation.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand bundle valid
in_ready  output  1  block can accept operands
A  input  WIDTH  operand A
B  input  WIDTH  operand B
Sub  input  1  0 = A+B, 1 = A-B (two's complement)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
S  output  WIDTH  sum/difference
Cout  output  1  final carry out; in subtract mode 1 = no borrow (A >= B unsigned)
V  output  1  signed overflow
Z  output  1  S == 0
N  output  1  S[WIDTH-1]

Behaviour:
- Reset (async, rst=1): state IDLE, in_ready=1, out_valid=0, S=0, Cout=0, V=0, Z=0, N=0, chunk counter=0.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid: latch A, B xor {WIDTH{Sub}}, carry register = Sub, counter = 0, go RUN. in_ready=0 from the next cycle.
- RUN: each cycle add lowest CHUNK bits of A-reg, B-reg and carry register; write CHUNK result bits into the top of the result shift register; shift A-reg/B-reg right by CHUNK; update carry register; counter += 1. On counter == NCH-1: go DONE.
- V computed on the last RUN cycle: carry into MSB xor carry out of MSB.
- DONE: out_valid=1; S, Cout, V, Z, N stable and held until out_ready=1. Transfer completes on out_valid & out_ready. Next cycle IDLE, out_valid=0. Outputs keep last value after transfer.
- Latency: operand accepted at edge k; out_valid=1 after edge k+NCH. Throughput: one operation per NCH+2 cycles minimum (no overlap).
- in_ready=0 in RUN and DONE; in_valid then ignored and must be held by upstream.
- out_ready while not DONE: no effect.
- NCH==1 (CHUNK==WIDTH): RUN lasts exactly one cycle.
- rst asserted mid-RUN or in DONE: operation discarded, reset values above, no partial result ever presented.
- Arithmetic modulo 2^WIDTH; Cout/V computed on unsaturated result.

Optional Feature:
SEQ_ADDSUB_SATURATE_EN. Defined: when V=1, S clamps to signed max (0 followed by ones) if the true result is positive, signed min (1 followed by zeros) if negative; Z/N reflect the clamped S; V and Cout still report the raw overflow/carry. Undefined: S is the wrapped result; no clamping logic.

Decomposition:
- Package seq_addsub_pkg: state encoding typedef (IDLE, RUN, DONE), helper constant for counter width from NCH.
- Sub-module addsub_slice: combinational CHUNK-bit ripple adder (a, b, cin -> s, cout, carry into MSB), instantiated once; B inversion done in the parent at operand latch.

Test Plan:
- WIDTH=16, CHUNK=4: A=0x0005, B=0x0003, Sub=0 -> after 4 cycles out_valid, S=0x0008, Cout=0, V=0, Z=0, N=0.
- A=0x0001, B=0x0002, Sub=1 -> S=0xFFFF, Cout=0, N=1, V=0; A=0x0005, B=0x0003, Sub=1 -> S=0x0002, Cout=1.
- A=0xFFFF, B=0x0001, Sub=0 -> S=0x0000, Cout=1, Z=1, V=0; A=0x7FFF, B=0x0001, Sub=0 -> S=0x8000, V=1 (with SEQ_ADDSUB_SATURATE_EN: S=0x7FFF, V=1, N=0).
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, S and flags stable, in_ready=0 throughout, new in_valid ignored; result transfers on the first out_ready=1 cycle.
- Reset mid-RUN (rst pulse at cycle 2 of 4) -> out_valid=0, in_ready=1 immediately, all outputs zero; next operation 0x1234+0x1111 -> S=0x2345.
- Parameter sweep: CHUNK=16 (NCH=1) and CHUNK=1 (NCH=16) with 0x8000-0x0001 -> S=0x7FFF, V=1, Cout=1, latency 1 and 16 cycles respectively.

Source files
------------

// File: rtl/seq_addsub_pkg.sv
// seq_addsub_pkg: shared FSM state encoding and chunk-counter sizing for seq_addsub.
package seq_addsub_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    function automatic int cnt_width(input int nch);
        return nch > 1 ? $clog2(nch) : 1;
    endfunction
endpackage

// File: rtl/seq_addsub_slice.sv
// addsub_slice: combinational CHUNK-bit ripple adder; also exposes the carry into its MSB.
module addsub_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             cmsb
);
    logic c;
    always_comb begin
        s    = '0;
        c    = cin;
        cmsb = cin;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) cmsb = c;
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end
endmodule

// File: rtl/seq_addsub.sv
// seq_addsub: multi-cycle add/sub, CHUNK bits per clock with valid/ready on both sides.
// Define SEQ_ADDSUB_SATURATE_EN to clamp S to the signed range on overflow.
module seq_addsub
    import seq_addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V,
    output logic             Z,
    output logic             N
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = cnt_width(NCH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d, cout_q, cout_d, v_q, v_d, z_q, z_d, n_q, n_d;
    logic [CHUNK-1:0] sl_s;
    logic             sl_co, sl_cm, last;
    logic [WIDTH-1:0] raw, res;

    addsub_slice #(.CHUNK(CHUNK)) u_slice (
        .a    (a_q[CHUNK-1:0]),
        .b    (b_q[CHUNK-1:0]),
        .cin  (c_q),
        .s    (sl_s),
        .cout (sl_co),
        .cmsb (sl_cm)
    );

    // Result bits enter at the top so the final chunk lands the word in place.
    if (NCH == 1) begin : g_one
        assign raw = sl_s;
    end else begin : g_many
        assign raw = {sl_s, r_q[WIDTH-1:CHUNK]};
    end

`ifdef SEQ_ADDSUB_SATURATE_EN
    assign res = !(sl_cm ^ sl_co) ? raw :
                 raw[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
`else
    assign res = raw;
`endif

    assign last = cnt_q == CW'(NCH - 1);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        cout_d  = cout_q;
        v_d     = v_q;
        z_d     = z_q;
        n_d     = n_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = A;
                b_d     = B ^ {WIDTH{Sub}};
                c_d     = Sub;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                a_d   = a_q >> CHUNK;
                b_d   = b_q >> CHUNK;
                c_d   = sl_co;
                r_d   = raw;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    state_d = DONE;
                    s_d     = res;
                    cout_d  = sl_co;
                    v_d     = sl_cm ^ sl_co;
                    z_d     = res == '0;
                    n_d     = res[WIDTH-1];
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            v_q     <= v_d;
            z_q     <= z_d;
            n_q     <= n_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign S         = s_q;
    assign Cout      = cout_q;
    assign V         = v_q;
    assign Z         = z_q;
    assign N         = n_q;
endmodule

// File: tb/tb_seq_addsub.sv
// tb_seq_addsub: directed scoreboard bench for seq_addsub at CHUNK=4, 16 and 1.
module tb_seq_addsub;
    typedef struct packed {
        logic [15:0] s;
        logic        c, v, z, n;
    } exp_t;

    logic        clk, rst, sub;
    logic [15:0] a, b;
    logic        iv [3];
    logic        ordy [3];
    logic        ir [3];
    logic        ov [3];
    logic [15:0] so [3];
    logic        co [3], vo [3], zo [3], no [3];
    exp_t        sb [$];
    int          compared = 0;
    int          mismatched = 0;

    seq_addsub #(.WIDTH(16), .CHUNK(4)) u0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .A(a), .B(b), .Sub(sub),
        .out_valid(ov[0]), .out_ready(ordy[0]), .S(so[0]), .Cout(co[0]), .V(vo[0]), .Z(zo[0]), .N(no[0]));
    seq_addsub #(.WIDTH(16), .CHUNK(16)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .A(a), .B(b), .Sub(sub),
        .out_valid(ov[1]), .out_ready(ordy[1]), .S(so[1]), .Cout(co[1]), .V(vo[1]), .Z(zo[1]), .N(no[1]));
    seq_addsub #(.WIDTH(16), .CHUNK(1)) u2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .A(a), .B(b), .Sub(sub),
        .out_valid(ov[2]), .out_ready(ordy[2]), .S(so[2]), .Cout(co[2]), .V(vo[2]), .Z(zo[2]), .N(no[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic m);
        exp_t        e;
        logic [15:0] yx;
        logic [16:0] f;
        yx  = m ? ~y : y;
        f   = {1'b0, x} + {1'b0, yx} + {16'd0, m};
        e.s = f[15:0];
        e.c = f[16];
        e.v = (x[15] == yx[15]) && (e.s[15] != x[15]);
`ifdef SEQ_ADDSUB_SATURATE_EN
        if (e.v) e.s = e.s[15] ? 16'h7FFF : 16'h8000;
`endif
        e.z = e.s == 16'h0;
        e.n = e.s[15];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input int k, input logic [15:0] x, input logic [15:0] y, input logic m);
        @(negedge clk);
        chk("in_ready_idle", 32'(ir[k]), 1);
        a = x; b = y; sub = m; iv[k] = 1'b1;
        sb.push_back(model(x, y, m));
        @(posedge clk);
        #1 iv[k] = 1'b0;
    endtask

    // Waits for the result, optionally stalls it for hold cycles, then transfers it.
    task automatic finish_op(input int k, input int lat, input int hold);
        int   n;
        exp_t e;
        n = 0;
        while (ov[k] !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        chk("latency", 32'(n), 32'(lat));
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 0, 1);
            return;
        end
        e = sb.pop_front();
        repeat (hold) begin
            @(negedge clk);
            chk("bp_valid", 32'(ov[k]), 1);
            chk("bp_in_ready", 32'(ir[k]), 0);
            chk("bp_S", 32'(so[k]), 32'(e.s));
            chk("bp_V", 32'(vo[k]), 32'(e.v));
            a = 16'h1111; b = 16'h2222; sub = 1'b0; iv[k] = 1'b1;
        end
        @(negedge clk);
        iv[k] = 1'b0;
        chk("S", 32'(so[k]), 32'(e.s));
        chk("Cout", 32'(co[k]), 32'(e.c));
        chk("V", 32'(vo[k]), 32'(e.v));
        chk("Z", 32'(zo[k]), 32'(e.z));
        chk("N", 32'(no[k]), 32'(e.n));
        ordy[k] = 1'b1;
        @(posedge clk);
        #1 ordy[k] = 1'b0;
        chk("valid_after_xfer", 32'(ov[k]), 0);
        chk("ready_after_xfer", 32'(ir[k]), 1);
        chk("S_held", 32'(so[k]), 32'(e.s));
    endtask

    initial begin
        rst = 1'b1; a = '0; b = '0; sub = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0;
            ordy[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(ir[0]), 1);
        chk("rst_out_valid", 32'(ov[0]), 0);
        chk("rst_S", 32'(so[0]), 0);
        chk("rst_flags", {28'd0, co[0], vo[0], zo[0], no[0]}, 0);
        rst = 1'b0;

        start_op(0, 16'h0005, 16'h0003, 1'b0); finish_op(0, 4, 0);
        start_op(0, 16'h0001, 16'h0002, 1'b1); finish_op(0, 4, 0);
        start_op(0, 16'h0005, 16'h0003, 1'b1); finish_op(0, 4, 0);
        start_op(0, 16'hFFFF, 16'h0001, 1'b0); finish_op(0, 4, 0);
        start_op(0, 16'h7FFF, 16'h0001, 1'b0); finish_op(0, 4, 5);
        start_op(0, 16'h8000, 16'h8000, 1'b0); finish_op(0, 4, 0);
        start_op(0, 16'hA5C3, 16'h3C5A, 1'b1); finish_op(0, 4, 2);
        chk("out_ready_idle_no_effect", 32'(ov[0]), 0);

        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0; iv[0] = 1'b1;
        @(posedge clk);
        #1 iv[0] = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(ov[0]), 0);
        chk("midrst_in_ready", 32'(ir[0]), 1);
        chk("midrst_S", 32'(so[0]), 0);
        chk("midrst_flags", {28'd0, co[0], vo[0], zo[0], no[0]}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("midrst_no_result", 32'(ov[0]), 0);
        end
        start_op(0, 16'h1234, 16'h1111, 1'b0); finish_op(0, 4, 0);

        start_op(1, 16'h8000, 16'h0001, 1'b1); finish_op(1, 1, 0);
        start_op(1, 16'h1234, 16'h1111, 1'b0); finish_op(1, 1, 0);
        start_op(2, 16'h8000, 16'h0001, 1'b1); finish_op(2, 16, 0);
        start_op(2, 16'h0001, 16'h0002, 1'b1); finish_op(2, 16, 0);

        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
